rs232_to_axis: RTL and testbench

RS232_TO_AXIS -- requirements
Module: rs232_to_axis

---
 rtl/rs232_to_axis.sv | 138 +++++++++++++
 tb/tb_rs232_to_axis.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs232_to_axis.sv
// RS-232 receiver (8N1) delivering bytes on an AXI-stream style valid/ready port.
// Define RS232_TO_AXIS_RTS_EN to drive rtsn_pin from the output-holding state.
module rs232_to_axis #(
    parameter int unsigned CLOCK_FREQ = 133000000,
    parameter int unsigned BAUD_RATE  = 115200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rxd_pin,
    output logic       rtsn_pin,
    output logic [7:0] odata,
    output logic       ovalid,
    input  logic       oready,
    output logic       ferror,
    output logic       overrun
);

    localparam int unsigned P  = (CLOCK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
    localparam int unsigned CW = $clog2(P);
    localparam logic [CW-1:0] FULL_LAST = CW'(P - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(P / 2 - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitHigh} state_e;

    state_e          r_state;
    logic            r_sync1, r_sync2;
    logic [1:0]      r_warm;
    logic            r_prev;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic [7:0]      r_data;
    logic            r_valid;
    logic            r_ferror;
    logic            r_overrun;
    logic            r_rtsn;

    logic w_rx, w_fall, w_tick_full, w_tick_half;
    logic w_done, w_take, w_load, w_valid_d;

    always_comb begin
        w_rx        = r_sync2;
        w_fall      = r_prev & ~w_rx;
        w_tick_full = (r_cnt == FULL_LAST);
        w_tick_half = (r_cnt == HALF_LAST);
        w_done      = (r_state == StStop) && w_tick_full && w_rx;
        w_take      = r_valid && oready;
        // A completing byte may replace the held one only if it leaves this cycle.
        w_load      = w_done && (!r_valid || oready);
        w_valid_d   = w_load || (r_valid && !w_take);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= StIdle;
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_warm    <= 2'b00;
            r_prev    <= 1'b0;
            r_cnt     <= '0;
            r_bit     <= 3'd0;
            r_shift   <= 8'h00;
            r_data    <= 8'h00;
            r_valid   <= 1'b0;
            r_ferror  <= 1'b0;
            r_overrun <= 1'b0;
            r_rtsn    <= 1'b1;
        end else begin
            r_sync1   <= rxd_pin;
            r_sync2   <= r_sync1;
            r_warm    <= {r_warm[0], 1'b1};
            // Edge history stays low until the synchronizer holds real line samples,
            // so a line that is low when reset releases is not taken as a start bit.
            r_prev    <= r_warm[1] & w_rx;
            r_ferror  <= 1'b0;
            r_overrun <= 1'b0;

            case (r_state)
                StIdle: begin
                    r_cnt <= '0;
                    if (w_fall) r_state <= StStart;
                end
                StStart: begin
                    if (w_tick_half) begin
                        r_cnt   <= '0;
                        r_bit   <= 3'd0;
                        r_state <= w_rx ? StIdle : StData;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StData: begin
                    if (w_tick_full) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx, r_shift[7:1]};
                        r_bit   <= r_bit + 1'b1;
                        if (r_bit == 3'd7) r_state <= StStop;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StStop: begin
                    if (w_tick_full) begin
                        r_cnt <= '0;
                        if (w_rx) begin
                            r_state <= StIdle;
                        end else begin
                            r_ferror <= 1'b1;
                            r_state  <= StWaitHigh;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StWaitHigh: begin
                    if (w_rx) r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase

            r_valid <= w_valid_d;
            if (w_load) r_data <= r_shift;
            if (w_done && !w_load) r_overrun <= 1'b1;
`ifdef RS232_TO_AXIS_RTS_EN
            r_rtsn <= w_valid_d;
`else
            r_rtsn <= 1'b0;
`endif
        end
    end

    assign odata    = r_data;
    assign ovalid   = r_valid;
    assign ferror   = r_ferror;
    assign overrun  = r_overrun;
    assign rtsn_pin = r_rtsn;

endmodule

// File: tb/tb_rs232_to_axis.sv
// Self-checking bench for rs232_to_axis: directed scenarios plus random frames,
// scored against a frame-level model of the receiver and its one-entry output slot.
module tb_rs232_to_axis;

    localparam int P = 16;
`ifdef RS232_TO_AXIS_RTS_EN
    localparam bit RTS_EN = 1'b1;
`else
    localparam bit RTS_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rxd_pin = 1'b1;
    logic       oready = 1'b1;
    logic       rtsn_pin;
    logic [7:0] odata;
    logic       ovalid;
    logic       ferror;
    logic       overrun;

    always #5 clock = ~clock;

    rs232_to_axis #(
        .CLOCK_FREQ(16),
        .BAUD_RATE (1)
    ) u_dut (
        .clock   (clock),
        .reset   (reset),
        .rxd_pin (rxd_pin),
        .rtsn_pin(rtsn_pin),
        .odata   (odata),
        .ovalid  (ovalid),
        .oready  (oready),
        .ferror  (ferror),
        .overrun (overrun)
    );

    int n_vec = 0;
    int n_mis = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: whole frames in, bytes out through a single holding slot.
    logic [7:0] exp_q[$];
    int         exp_ferr = 0;
    int         m_ovr = 0;
    logic       m_full = 1'b0;
    logic [7:0] m_data = 8'h00;

    function automatic void model_frame(input logic [7:0] d, input logic stop);
        if (!stop) exp_ferr++;
        else if (m_full) m_ovr++;
        else begin
            m_full = 1'b1;
            m_data = d;
        end
    endfunction

    function automatic void model_drain();
        if (m_full) exp_q.push_back(m_data);
        m_full = 1'b0;
    endfunction

    // Monitor, sampling on the falling edge.
    int         cyc = 0;
    logic       rst_q = 1'b1;
    logic [7:0] rx_q[$];
    int         n_ferr = 0, n_ovr = 0, n_vcyc = 0, rise_cyc = -1, streak = 0;
    logic       hold_q = 1'b0, prev_valid = 1'b0, rdy_rand = 1'b0;
    logic [7:0] hold_data = 8'h00;

    initial forever begin
        @(posedge clock);
        rst_q = reset;
    end

    initial forever begin
        @(negedge clock);
        cyc++;
        if (rst_q) begin
            check_eq("rst_ovalid", 32'(ovalid), 32'h0);
            check_eq("rst_odata", 32'(odata), 32'h0);
            check_eq("rst_ferror", 32'(ferror), 32'h0);
            check_eq("rst_overrun", 32'(overrun), 32'h0);
            check_eq("rst_rtsn", 32'(rtsn_pin), 32'h1);
            hold_q = 1'b0;
            prev_valid = 1'b0;
            streak = 0;
        end else begin
            if (hold_q) begin
                check_eq("hold_valid", 32'(ovalid), 32'h1);
                check_eq("hold_data", 32'(odata), 32'(hold_data));
            end
            check_eq("rtsn", 32'(rtsn_pin), RTS_EN ? 32'(ovalid) : 32'h0);
            if (ovalid && !prev_valid) rise_cyc = cyc;
            if (ovalid && oready) rx_q.push_back(odata);
            n_vcyc += int'(ovalid);
            n_ferr += int'(ferror);
            n_ovr  += int'(overrun);
            streak = ovalid ? streak + 1 : 0;
            hold_q = ovalid && !oready;
            hold_data = odata;
            prev_valid = ovalid;
        end
    end

    // Random sink readiness, never stalling a byte for long.
    initial forever begin
        @(posedge clock);
        #1;
        if (rdy_rand) oready = (streak >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, output int t0);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        t0 = cyc;
        for (int i = 0; i < 10; i++) begin
            rxd_pin = bits[i];
            repeat (P) @(posedge clock);
            #1;
        end
    endtask

    task automatic glitch(input int k);
        rxd_pin = 1'b0;
        repeat (k) @(posedge clock);
        #1;
        rxd_pin = 1'b1;
    endtask

    task automatic compare_stream(input string tag);
        check_eq({tag, "_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check_eq({tag, "_byte"}, 32'(rx_q[i]), 32'(exp_q[i]));
        check_eq({tag, "_ferr"}, n_ferr, exp_ferr);
        check_eq({tag, "_ovr"}, n_ovr, m_ovr);
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int         t0, v0, kind;
        logic [7:0] d;

        repeat (4) @(posedge clock);
        #1;
        reset = 1'b0;
        wait_cycles(10);

        // Clean frame, sink always ready: one valid cycle inside the stop bit.
        v0 = n_vcyc;
        send_frame(8'h55, 1'b1, t0);
        model_frame(8'h55, 1'b1);
        model_drain();
        wait_cycles(20);
        check_eq("t030_rise_window", 32'((rise_cyc - t0 >= 146) && (rise_cyc - t0 <= 166)), 32'h1);
        check_eq("t030_valid_cycles", n_vcyc - v0, 1);
        compare_stream("t030");

        // Short low pulse is rejected.
        v0 = n_vcyc;
        glitch(5);
        wait_cycles(40);
        check_eq("t031_valid_cycles", n_vcyc - v0, 0);
        compare_stream("t031");

        // Framing error with the line held low, then a good frame.
        v0 = n_vcyc;
        send_frame(8'hA3, 1'b0, t0);
        model_frame(8'hA3, 1'b0);
        wait_cycles(40);
        rxd_pin = 1'b1;
        wait_cycles(10);
        check_eq("t032_valid_cycles", n_vcyc - v0, 0);
        compare_stream("t032_err");
        send_frame(8'h12, 1'b1, t0);
        model_frame(8'h12, 1'b1);
        model_drain();
        wait_cycles(20);
        compare_stream("t032_next");

        // Stalled sink: second byte is dropped, first is kept.
        oready = 1'b0;
        send_frame(8'h01, 1'b1, t0);
        model_frame(8'h01, 1'b1);
        wait_cycles(5);
        send_frame(8'h02, 1'b1, t0);
        model_frame(8'h02, 1'b1);
        wait_cycles(20);
        check_eq("t033_valid", 32'(ovalid), 32'(m_full));
        check_eq("t033_data", 32'(odata), 32'(m_data));
        oready = 1'b1;
        model_drain();
        wait_cycles(5);
        compare_stream("t033");

        // One-cycle reset in the middle of data bit 4 abandons the frame.
        fork
            send_frame(8'hC8, 1'b1, t0);
            begin
                repeat (5 * P + 8) @(posedge clock);
                #1;
                reset = 1'b1;
                @(posedge clock);
                #1;
                reset = 1'b0;
            end
        join
        wait_cycles(20);
        compare_stream("t034_abort");
        send_frame(8'hC8, 1'b1, t0);
        model_frame(8'hC8, 1'b1);
        model_drain();
        wait_cycles(20);
        compare_stream("t034_next");

        // Request-to-send while a byte is held, and after its handshake.
        oready = 1'b0;
        send_frame(8'h7E, 1'b1, t0);
        model_frame(8'h7E, 1'b1);
        wait_cycles(20);
        check_eq("t035_rtsn_held", 32'(rtsn_pin), 32'(RTS_EN));
        oready = 1'b1;
        #1;
        check_eq("t035_rtsn_hs", 32'(rtsn_pin), 32'(RTS_EN));
        @(posedge clock);
        #1;
        check_eq("t035_rtsn_after", 32'(rtsn_pin), 32'h0);
        model_drain();
        wait_cycles(5);
        compare_stream("t035");

        // Random mix of good frames, framing errors and glitches.
        rdy_rand = 1'b1;
        for (int it = 0; it < 14; it++) begin
            kind = int'($urandom_range(0, 9));
            d = 8'($urandom);
            if (kind == 0) begin
                glitch(int'($urandom_range(1, 5)));
                wait_cycles(25);
            end else if (kind == 1) begin
                send_frame(d, 1'b0, t0);
                model_frame(d, 1'b0);
                wait_cycles(int'($urandom_range(20, 50)));
                rxd_pin = 1'b1;
                wait_cycles(5);
            end else begin
                send_frame(d, 1'b1, t0);
                model_frame(d, 1'b1);
                model_drain();
                wait_cycles(int'($urandom_range(0, 30)));
            end
        end
        wait_cycles(30);
        rdy_rand = 1'b0;
        oready = 1'b1;
        wait_cycles(5);
        compare_stream("rand");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
